// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath: walks fetch/decode/
// execute/memory/writeback states and decodes the datapath control lines from the state.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    stateT stateR;
    stateT nextS;

    // State register; reset forces INIT so every write strobe drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= INIT;
        end else begin
            stateR <= nextS;
        end
    end

    // Next-state selection and Moore control decode
    always_comb begin
        nextS       = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        case (stateR)
            INIT: begin
                nextS = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nextS   = DECODE;
                end else begin
                    nextS   = FETCH;
                end
            end
            DECODE: begin
                // Branch target is precomputed here so BRANCH can use ALUOut
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     nextS = EXEC;
                    OP_LW, OP_SW: nextS = MEMADR;
                    OP_BEQ:       nextS = BRANCH;
                    OP_J:         nextS = JUMP;
                    OP_ADDI:      nextS = ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        nextS      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW) begin
                    nextS = MEMRD;
                end else if (opcode == OP_SW) begin
                    nextS = MEMWR;
                end else begin
                    nextS = FETCH;
                end
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nextS = MEMWB;
                end else begin
                    nextS = MEMRD;
                end
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                nextS      = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nextS      = FETCH;
                end else begin
                    nextS      = MEMWR;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nextS   = RWB;
            end
            RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextS      = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                nextS       = FETCH;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                nextS      = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nextS   = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextS      = FETCH;
            end
            default: begin
                // Unused codes recover through FETCH with all controls idle
                nextS = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: a per-instruction control-word
// reference model queues expected vectors; a negedge monitor compares them.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word: one bit per field, multi-bit selects in place
    logic [17:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

    localparam logic [17:0] PCW      = 18'h20000;
    localparam logic [17:0] PCWC     = 18'h10000;
    localparam logic [17:0] IORD     = 18'h08000;
    localparam logic [17:0] MRD      = 18'h04000;
    localparam logic [17:0] MWR      = 18'h02000;
    localparam logic [17:0] IRW      = 18'h01000;
    localparam logic [17:0] M2R      = 18'h00800;
    localparam logic [17:0] RDST     = 18'h00400;
    localparam logic [17:0] RWR      = 18'h00200;
    localparam logic [17:0] SRCA     = 18'h00100;
    localparam logic [17:0] SRCB_4   = 18'h00040;
    localparam logic [17:0] SRCB_IMM = 18'h00080;
    localparam logic [17:0] SRCB_SH  = 18'h000C0;
    localparam logic [17:0] ALU_SUB  = 18'h00010;
    localparam logic [17:0] ALU_FN   = 18'h00020;
    localparam logic [17:0] PCS_AO   = 18'h00004;
    localparam logic [17:0] PCS_JMP  = 18'h00008;
    localparam logic [17:0] DONE     = 18'h00002;
    localparam logic [17:0] ILL      = 18'h00001;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic [17:0] expQ[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int expDone = 0;
    int obsDone = 0;

    // Monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (instr_done === 1'b1) obsDone++;
        if (expQ.size() > 0) begin
            logic [17:0] e;
            e = expQ.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL ctrl cyc=%0d got=%05h want=%05h", cyc, obs, e);
            end
        end
    end

    function automatic bit isLegal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_J || op == OP_ADDI;
    endfunction

    task automatic step(input logic mr, input logic [5:0] op, input logic [17:0] e);
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        expQ.push_back(e);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic doReset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst_n     = 1'b0;
            mem_ready = 1'b1;
            expQ.push_back(18'h00000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expQ.push_back(18'h00000);
    endtask

    // Reference: the control words an instruction produces, cycle by cycle
    task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input bit abortWb);
        repeat (fw) step(1'b0, 6'($urandom), MRD | SRCB_4);
        step(1'b1, 6'($urandom), MRD | SRCB_4 | IRW | PCW);
        step(rnd(), op, SRCB_SH | (isLegal(op) ? 18'h00000 : ILL));
        case (op)
            OP_R: begin
                step(rnd(), op, SRCA | ALU_FN);
                step(rnd(), op, RDST | RWR | DONE);
                expDone++;
            end
            OP_LW: begin
                step(rnd(), op, SRCA | SRCB_IMM);
                repeat (mw) step(1'b0, op, MRD | IORD);
                step(1'b1, op, MRD | IORD);
                step(rnd(), op, RWR | M2R | DONE);
                if (abortWb) begin
                    @(negedge clk);
                    #1;
                    rst_n = 1'b0;
                    #1;
                    total++;
                    if (obs !== 18'h00000) begin
                        bad++;
                        $display("FAIL async_abort got=%05h want=%05h", obs, 18'h00000);
                    end
                    doReset(1);
                end
                expDone++;
            end
            OP_SW: begin
                step(rnd(), op, SRCA | SRCB_IMM);
                repeat (mw) step(1'b0, op, MWR | IORD);
                step(1'b1, op, MWR | IORD | DONE);
                expDone++;
            end
            OP_BEQ: begin
                step(rnd(), op, SRCA | ALU_SUB | PCWC | PCS_AO | DONE);
                expDone++;
            end
            OP_J: begin
                step(rnd(), op, PCW | PCS_JMP | DONE);
                expDone++;
            end
            OP_ADDI: begin
                step(rnd(), op, SRCA | SRCB_IMM);
                step(rnd(), op, RWR | DONE);
                expDone++;
            end
            default: begin
            end
        endcase
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;

        doReset(3);
        runInstr(OP_R, 0, 0, 1'b0);
        runInstr(OP_LW, 0, 0, 1'b0);
        runInstr(OP_SW, 0, 3, 1'b0);
        runInstr(OP_BEQ, 0, 0, 1'b0);
        runInstr(OP_J, 0, 0, 1'b0);
        runInstr(6'b111111, 0, 0, 1'b0);
        runInstr(OP_LW, 1, 2, 1'b1);
        runInstr(OP_ADDI, 0, 0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom); while (isLegal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                     (op == OP_LW) && ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        #2;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", expQ.size());
        end
        total++;
        if (obsDone != expDone) begin
            bad++;
            $display("FAIL done_count got=%0d want=%0d", obsDone, expDone);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control sequencer for the multi-cycle MIPS datapath. It takes the 6-bit opcode from the instruction register and steps through fetch, decode, execute, memory and writeback states. In each state it drives the datapath control lines, which are Moore outputs decoded from the current state. It also adds a memory-ready handshake, an end-of-instruction strobe and illegal-opcode detection. It sits between the instruction register and the shared memory/ALU/register-file datapath.

## Interface
- No parameters. The state encoding is fixed (see Operation).
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from the instruction register; sampled only in DECODE
- mem_ready  input  1  memory has completed the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU zero (datapath ANDs with zero)
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load the instruction register
- MemToReg  output  1  register write data select: 0=ALUOut, 1=MDR
- RegDst  output  1  write register select: 0=rt, 1=rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0=PC, 1=A register
- ALUSrcB  output  2  ALU B select: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
- PCSource  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- Decoded opcodes:
  - R-type 000000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
  - ADDI 001000
- State encoding (4 bits):
  - INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12
  - Codes 13-15 go to FETCH on the next clock.
- Every output is 0 unless it is listed for the current state.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, ALUSrcB=01.
  - When mem_ready=1, also IRWrite=1 and PCWrite=1.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE: ALUSrcB=11 (branch target into ALUOut).
  - R-type -> EXEC; LW/SW -> MEMADR; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDIEX.
  - Any other opcode: illegal_op=1, next state FETCH; no register or memory side effects.
- MEMADR: ALUSrcA=1, ALUSrcB=10. LW -> MEMRD; SW -> MEMWR. The opcode is held stable by the instruction register.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, instr_done=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1.
  - When mem_ready=1: instr_done=1 and next state FETCH.
  - Otherwise stays in MEMWR.
- EXEC: ALUSrcA=1, ALUOp=10. Next state RWB.
- RWB: RegDst=1, RegWrite=1, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: RegWrite=1, instr_done=1. Next state FETCH.
- Only the FETCH and MEMWR outputs depend on mem_ready. All other outputs are pure functions of the state register.

## Timing
- While rst_n=0: state=INIT and all outputs are 0, immediately and independent of clk.
- After rst_n deasserts: the first rising edge enters INIT->FETCH transition timing, so FETCH is entered on the second edge.
- Cycles per instruction with mem_ready held at 1:
  - R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- instr_done is high for exactly one cycle per completed instruction. It is never high in a wait cycle.
- Illegal opcode: 2 cycles (FETCH, DECODE). instr_done stays 0.
- Reset asserted mid-instruction: return to INIT immediately and abort any pending write. MemWrite and RegWrite drop in the same cycle.
- A mem_ready pulse outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> all outputs 0. On release, FETCH is reached after 2 edges with MemRead=1, ALUSrcB=01, IRWrite=1, PCWrite=1.
- R-type then LW, mem_ready=1 -> state sequence 1,2,7,8 then 1,2,3,4,5. instr_done pulses at cycles 4 and 9. RegDst=1 only in RWB.
- SW with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, IorD=1, instr_done=1 only in the last of those cycles.
- BEQ and J back-to-back -> 3 cycles each. PCWriteCond=1 with PCSource=01 in BRANCH. PCWrite=1 with PCSource=10 in JUMP.
- Opcode 6'b111111 -> illegal_op pulses in DECODE, next state is FETCH, RegWrite and MemWrite never assert.
- rst_n pulsed low while in MEMWB -> RegWrite drops asynchronously and state=INIT. A subsequent ADDI completes in 4 cycles with RegWrite=1, RegDst=0, MemToReg=0 in ADDIWB.
